// File: rtl/dm_resp_if.sv
// -----------------------------------------------------------------------------
// dm_resp_if
//   CPU data-access bus with a valid/ready handshake on both the request
//   and the response channel.
//   master : the CPU side. It drives the request fields and resp_ready.
//   slave  : the memory side (dm_resp). It drives req_ready and the
//            response fields.
//   Request : req_valid/req_ready, req_we, req_addr, req_be, req_wdata, req_pc
//   Response: resp_valid/resp_ready, resp_rdata, resp_err
// -----------------------------------------------------------------------------
interface dm_resp_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic [31:0] req_pc;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_be, req_wdata, req_pc, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_be, req_wdata, req_pc, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dm_resp.sv
// -----------------------------------------------------------------------------
// dm_resp
//   Data-memory responder. It accepts one load or store at a time and
//   answers after a fixed latency of LATENCY edges. A store writes only the
//   byte lanes whose enable bit is set. A load returns the whole word, and
//   the CPU extracts the lanes it needs. Each committed store is printed to
//   the simulation log.
//   Ports:
//     clk   - rising-edge clock
//     reset - asynchronous, active-high; clears the FSM and every memory word
//     bus   - dm_resp_if.slave (request and response handshake channels)
//   Parameters:
//     DEPTH   - number of 32-bit words
//     LATENCY - edges from acceptance to resp_valid rising, 1..15
// -----------------------------------------------------------------------------
module dm_resp #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic       clk,
  input  logic       reset,
  dm_resp_if.slave   bus
);

  localparam int         IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] LAT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] pc_q, pc_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;

  logic [31:0] mem_q [DEPTH];

  // Commit-side view of the request. With LATENCY=1 the commit happens on the
  // acceptance edge, so the fields come straight from the bus. Otherwise they
  // come from the copy latched at acceptance.
  logic             c_we;
  logic [31:0]      c_addr;
  logic [3:0]       c_be;
  logic [31:0]      c_wdata;
  logic [31:0]      c_pc;
  logic [IDX_W-1:0] c_idx;
  logic             be_ok;
  logic             idx_ok;
  logic             c_err;
  logic [31:0]      old_word;
  logic [31:0]      merged_word;
  logic             commit;
  logic             mem_we;

  always_comb begin
    if (state_q == BUSY) begin
      c_we    = we_q;
      c_addr  = addr_q;
      c_be    = be_q;
      c_wdata = wdata_q;
      c_pc    = pc_q;
    end else begin
      c_we    = bus.req_we;
      c_addr  = bus.req_addr;
      c_be    = bus.req_be;
      c_wdata = bus.req_wdata;
      c_pc    = bus.req_pc;
    end
  end

  // Only naturally sized byte, halfword and word enables are legal.
  always_comb begin
    case (c_be)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: be_ok = 1'b1;
      default:                   be_ok = 1'b0;
    endcase
  end

  // Compare the full 30-bit word index, so high addresses are rejected
  // instead of wrapping into the array.
  assign idx_ok   = ({2'b00, c_addr[31:2]} < 32'(DEPTH));
  assign c_idx    = c_addr[IDX_W+1:2];
  assign c_err    = !be_ok || !idx_ok;
  assign old_word = mem_q[c_idx];

  always_comb begin
    merged_word = old_word;
    for (int i = 0; i < 4; i++) begin
      if (c_be[i]) merged_word[8*i +: 8] = c_wdata[8*i +: 8];
    end
  end

  // NOTE: every variable gets its default before the case statement.
  // Otherwise a path that does not assign it would infer a latch.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    addr_d       = addr_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    pc_d         = pc_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    commit       = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          addr_d  = bus.req_addr;
          be_d    = bus.req_be;
          wdata_d = bus.req_wdata;
          pc_d    = bus.req_pc;
          if (LATENCY == 1) begin
            state_d = RESP;
            commit  = 1'b1;
          end else begin
            state_d = BUSY;
            cnt_d   = LAT_INIT;
          end
        end
      end
      BUSY: begin
        if (cnt_q == 4'd1) begin
          state_d = RESP;
          cnt_d   = 4'd0;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (bus.resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
          resp_rdata_d = 32'h0;
          resp_err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (commit) begin
      resp_valid_d = 1'b1;
      resp_err_d   = c_err;
      resp_rdata_d = (c_we || c_err) ? 32'h0 : old_word;
    end
  end

  assign mem_we = commit && c_we && !c_err;

  // NOTE: state uses non-blocking assignments. Every flop then samples its
  // pre-edge value, whatever order the always blocks are evaluated in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      we_q         <= 1'b0;
      addr_q       <= 32'h0;
      be_q         <= 4'h0;
      wdata_q      <= 32'h0;
      pc_q         <= 32'h0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      be_q         <= be_d;
      wdata_q      <= wdata_d;
      pc_q         <= pc_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // NOTE: reset clears the whole array, so software sees all-zero memory.
  // Because of this the storage is built from flops and cannot map onto a
  // RAM macro.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 32'h0;
    end else if (mem_we) begin
      mem_q[c_idx] <= merged_word;
    end
  end

`ifndef SYNTHESIS
  // Store trace in the team log format. The address is word-aligned.
  always @(posedge clk) begin
    if (!reset && mem_we)
      $display("@%h: *%h <= %h", c_pc, c_addr & 32'hFFFF_FFFC, merged_word);
  end
`endif

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;

endmodule
